// File: rtl/fc1_weight_feeder_if.sv
// Host-push / fcn-consumer bundle for the fc1 weight feeder.
interface fc1_weight_feeder_if #(
    parameter int unsigned NUM_PE       = 4,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned TOTAL_GROUPS = 330
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = $clog2(TOTAL_GROUPS);
    localparam int unsigned PW = NUM_PE * 8;

    logic          clear;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic          full;
    logic [LW-1:0] level;
    logic          start;
    logic          next;
    logic [PW-1:0] w_out;
    logic          w_valid;
    logic [GW-1:0] group_idx;
    logic          last;
    logic          done;
    logic          overflow;
    logic          underrun;

    modport master (
        output clear, wr_en, wr_data, start, next,
        input  full, level, w_out, w_valid, group_idx, last, done, overflow, underrun
    );

    modport slave (
        input  clear, wr_en, wr_data, start, next,
        output full, level, w_out, w_valid, group_idx, last, done, overflow, underrun
    );
endinterface

// File: rtl/fc1_weight_feeder.sv
// Buffers host-pushed weight words in a circular FIFO and streams one group
// per consumer handshake to the fc1 PE lanes for a full inference.
module fc1_weight_feeder #(
    parameter int unsigned NUM_PE       = 4,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned TOTAL_GROUPS = 330
) (
    input  logic                 clk,
    input  logic                 rst,
    fc1_weight_feeder_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned GW = $clog2(TOTAL_GROUPS);
    localparam int unsigned PW = NUM_PE * 8;
    localparam logic [GW-1:0] IDX_LAST = GW'(TOTAL_GROUPS - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] w_out_q, w_out_d;
    logic          w_valid_q, w_valid_d;
    logic [GW-1:0] group_idx_q, group_idx_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;
    logic          underrun_q, underrun_d;
    logic          push, pop, empty;

    // Next-state: FSM decides pops on pre-write state, FIFO accounting follows.
    always_comb begin
        state_d     = state_q;
        w_out_d     = w_out_q;
        group_idx_d = group_idx_q;
        overflow_d  = overflow_q;
        underrun_d  = underrun_q;
        pop         = 1'b0;
        empty       = (level_q == '0);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    group_idx_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.next) begin
                    if (group_idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        group_idx_d = group_idx_q + GW'(1);
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = S_LOAD;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (pop) w_out_d = PW'(mem_q[rd_ptr_q]);

        push = bus.wr_en && (!full_q || pop);
        if (bus.wr_en && !push) overflow_d = 1'b1;

        // Flush overrides everything, including a coincident push.
        if (bus.clear) begin
            state_d     = S_IDLE;
            pop         = 1'b0;
            push        = 1'b0;
            w_out_d     = '0;
            group_idx_d = '0;
            overflow_d  = 1'b0;
            underrun_d  = 1'b0;
        end

        wr_ptr_d = bus.clear ? '0 : (push ? wr_ptr_q + AW'(1) : wr_ptr_q);
        rd_ptr_d = bus.clear ? '0 : (pop  ? rd_ptr_q + AW'(1) : rd_ptr_q);
        level_d  = bus.clear ? '0 : level_q + LW'(push) - LW'(pop);
        full_d   = (level_d == LVL_FULL);

        w_valid_d = (state_d == S_HOLD);
        last_d    = w_valid_d && (group_idx_d == IDX_LAST);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            w_out_q     <= '0;
            w_valid_q   <= 1'b0;
            group_idx_q <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            w_out_q     <= w_out_d;
            w_valid_q   <= w_valid_d;
            group_idx_q <= group_idx_d;
            last_q      <= last_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.full      = full_q;
    assign bus.level     = level_q;
    assign bus.w_out     = w_out_q;
    assign bus.w_valid   = w_valid_q;
    assign bus.group_idx = group_idx_q;
    assign bus.last      = last_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
    assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_fc1_weight_feeder.sv
// Scoreboard bench for fc1_weight_feeder: accepted pushes are queued and
// compared against each group the feeder presents.
module tb_fc1_weight_feeder;
    localparam int unsigned NUM_PE       = 4;
    localparam int unsigned DEPTH        = 16;
    localparam int unsigned TOTAL_GROUPS = 330;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    fc1_weight_feeder_if #(.NUM_PE(NUM_PE), .DEPTH(DEPTH), .TOTAL_GROUPS(TOTAL_GROUPS)) bus ();

    fc1_weight_feeder #(.NUM_PE(NUM_PE), .DEPTH(DEPTH), .TOTAL_GROUPS(TOTAL_GROUPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        sb.push_back(w);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        sb.delete();
    endtask

    // Compare the presented group against the oldest accepted word.
    task automatic check_group(input string tag, input int idx);
        logic [31:0] exp;
        check_eq({tag, "_valid"}, 64'(bus.w_valid), 64'd1);
        check_eq({tag, "_idx"}, 64'(bus.group_idx), 64'(idx));
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_sb: got group 0x%0h expected none queued", tag, bus.w_out);
        end else begin
            exp = sb.pop_front();
            check_eq({tag, "_data"}, 64'(bus.w_out), 64'(exp));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int pushed;
        bus.clear = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0;
        bus.start = 1'b0; bus.next = 1'b0;
        repeat (3) step();

        check_eq("rst_level", 64'(bus.level), 64'd0);
        check_eq("rst_full", 64'(bus.full), 64'd0);
        check_eq("rst_valid", 64'(bus.w_valid), 64'd0);
        check_eq("rst_wout", 64'(bus.w_out), 64'd0);
        check_eq("rst_idx", 64'(bus.group_idx), 64'd0);
        check_eq("rst_flags", 64'({bus.last, bus.done, bus.overflow, bus.underrun}), 64'd0);
        rst = 1'b0;
        step();

        // Basic fill, start, advance.
        push_word(32'h04030201);
        push_word(32'h08070605);
        push_word(32'h0C0B0A09);
        check_eq("b_level", 64'(bus.level), 64'd3);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check_group("b_g0", 0);
        check_eq("b_level2", 64'(bus.level), 64'd2);
        step();
        check_eq("b_hold", 64'(bus.w_out), 64'h04030201);
        bus.next = 1'b1; step(); bus.next = 1'b0;
        check_group("b_g1", 1);
        do_clear();

        // Start on an empty FIFO waits in LOAD.
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check_eq("l_valid0", 64'(bus.w_valid), 64'd0);
        step();
        check_eq("l_valid1", 64'(bus.w_valid), 64'd0);
        push_word(32'hFF80017F);
        check_eq("l_valid2", 64'(bus.w_valid), 64'd0);
        step();
        check_eq("l_lane0", 64'($signed(bus.w_out[7:0])),   64'(127));
        check_eq("l_lane1", 64'($signed(bus.w_out[15:8])),  64'(1));
        check_eq("l_lane2", 64'($signed(bus.w_out[23:16])), -64'sd128);
        check_eq("l_lane3", 64'($signed(bus.w_out[31:24])), -64'sd1);
        check_group("l_g0", 0);
        check_eq("l_underrun", 64'(bus.underrun), 64'd0);
        do_clear();

        // Overflow and push-with-pop while full.
        for (int i = 0; i < int'(DEPTH); i++) push_word($urandom);
        check_eq("o_full", 64'(bus.full), 64'd1);
        check_eq("o_level", 64'(bus.level), 64'(DEPTH));
        bus.wr_en = 1'b1; bus.wr_data = 32'hDEADBEEF; step(); bus.wr_en = 1'b0;
        check_eq("o_ovf", 64'(bus.overflow), 64'd1);
        check_eq("o_level2", 64'(bus.level), 64'(DEPTH));
        w = $urandom;
        sb.push_back(w);
        bus.wr_en = 1'b1; bus.wr_data = w; bus.start = 1'b1;
        step();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        check_eq("o_level3", 64'(bus.level), 64'(DEPTH));
        check_eq("o_full2", 64'(bus.full), 64'd1);
        check_group("o_g0", 0);
        for (int g = 1; g <= int'(DEPTH); g++) begin
            bus.next = 1'b1; step(); bus.next = 1'b0;
            check_group("o_gn", g);
        end
        do_clear();

        // Underrun at group 5, recovery, then clear mid-stream.
        for (int i = 0; i < 6; i++) push_word($urandom);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check_group("u_g0", 0);
        for (int g = 1; g <= 5; g++) begin
            bus.next = 1'b1; step(); bus.next = 1'b0;
            check_group("u_gn", g);
        end
        bus.next = 1'b1; step(); bus.next = 1'b0;
        check_eq("u_underrun", 64'(bus.underrun), 64'd1);
        check_eq("u_valid", 64'(bus.w_valid), 64'd0);
        check_eq("u_idx", 64'(bus.group_idx), 64'd6);
        push_word($urandom);
        step();
        check_group("u_g6", 6);
        push_word($urandom);
        bus.wr_en = 1'b1; bus.wr_data = $urandom;
        do_clear();
        bus.wr_en = 1'b0;
        check_eq("c_level", 64'(bus.level), 64'd0);
        check_eq("c_valid", 64'(bus.w_valid), 64'd0);
        check_eq("c_idx", 64'(bus.group_idx), 64'd0);
        check_eq("c_flags", 64'({bus.full, bus.overflow, bus.underrun}), 64'd0);

        // Full inference with the FIFO kept non-empty.
        pushed = 0;
        for (int i = 0; i < 4; i++) begin push_word($urandom); pushed++; end
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check_group("s_g0", 0);
        check_eq("s_last0", 64'(bus.last), 64'd0);
        for (int g = 1; g < int'(TOTAL_GROUPS); g++) begin
            bus.next = 1'b1;
            if (pushed < int'(TOTAL_GROUPS)) begin
                w = $urandom;
                bus.wr_en = 1'b1; bus.wr_data = w;
                sb.push_back(w);
                pushed++;
            end
            step();
            bus.next = 1'b0; bus.wr_en = 1'b0;
            check_group("s_gn", g);
            check_eq("s_last", 64'(bus.last), 64'(g == int'(TOTAL_GROUPS) - 1));
        end
        check_eq("s_underrun", 64'(bus.underrun), 64'd0);
        bus.next = 1'b1; step(); bus.next = 1'b0;
        check_eq("s_valid_end", 64'(bus.w_valid), 64'd0);
        check_eq("s_done1", 64'(bus.done), 64'd1);
        step();
        check_eq("s_done2", 64'(bus.done), 64'd0);
        check_eq("s_last_end", 64'(bus.last), 64'd0);
        bus.next = 1'b1; step(); bus.next = 1'b0;
        check_eq("s_next_ign", 64'({bus.w_valid, bus.done}), 64'd0);
        check_eq("s_idx_end", 64'(bus.group_idx), 64'(TOTAL_GROUPS - 1));
        check_eq("s_sb_empty", 64'(sb.size()), 64'd0);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check_eq("s_restart_idx", 64'(bus.group_idx), 64'd0);
        check_eq("s_restart_valid", 64'(bus.w_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
